// File: rtl/mod3_pkg.sv
// mod3_pkg
// Shared definitions for the bit-serial remainder-mod-3 datapath:
//   - ctrl_state_t : controller state encoding (IDLE, SHIFT, DONE)
//   - rem_t        : remainder tracker encoding (R0, R1, R2)
//   - rem_next()   : tracker transition r' = (2r + b) mod 3
package mod3_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } ctrl_state_t;

   typedef enum logic [1:0] {
      R0 = 2'b00,
      R1 = 2'b01,
      R2 = 2'b10
   } rem_t;

   // Appending bit b to a value with remainder r gives remainder (2r + b) mod 3.
   // The unused encoding maps back to R0 so a corrupted tracker self-heals.
   function automatic rem_t rem_next(input rem_t r, input logic b);
      rem_t n;
      case (r)
         R0:      n = b ? R1 : R0;
         R1:      n = b ? R0 : R2;
         R2:      n = b ? R2 : R1;
         default: n = R0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mod3_bit_fsm.sv
// mod3_bit_fsm
// Bit-serial remainder tracker: consumes one bit per enabled clock, MSB first,
// and holds the remainder of the bits seen so far modulo 3.
// Ports:
//   Clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset (tracker -> R0)
//   clr    in   synchronous clear to R0; wins over en
//   en     in   consume bit_in this edge
//   bit_in in   next operand bit
//   rem    out  current remainder (R0/R1/R2)
module mod3_bit_fsm
   import mod3_pkg::*;
(
   input  logic       Clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [1:0] rem
);

   rem_t rem_r;
   rem_t rem_nxt;

   // Next tracker value: clear, consume a bit, or hold (an illegal code falls back to R0).
   always_comb begin
      rem_nxt = rem_r;
      if (clr) begin
         rem_nxt = R0;
      end else if (en) begin
         rem_nxt = rem_next(rem_r, bit_in);
      end else begin
         case (rem_r)
            R0, R1, R2: rem_nxt = rem_r;
            default:    rem_nxt = R0;
         endcase
      end
   end

   // Tracker state register.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         rem_r <= R0;
      end else begin
         rem_r <= rem_nxt;
      end
   end

   assign rem = rem_r;

endmodule

// File: rtl/mod3_serial_ctrl.sv
// mod3_serial_ctrl
// Sequencer between a parallel host handshake and the bit-serial mod-3 tracker.
// A word accepted on start is shifted MSB-first into the tracker, one bit per
// clock for W clocks, then REM/divisible are published with a one-cycle done.
// Parameters:
//   W           operand width (>= 1)
// Ports:
//   Clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   process Data; honoured only while ready=1
//   Data[W-1:0] in   operand, captured on the accepted start edge
//   ready       out  IDLE or DONE: start is accepted this cycle
//   busy        out  SHIFT in progress
//   done        out  one-cycle pulse, new REM/divisible valid from here on
//   REM[1:0]    out  Data mod 3 of the last completed operation
//   divisible   out  REM == 0 for the last completed operation
//   div_count   out  (only with MOD3_DIV_COUNT_EN) wrapping count of
//                    divisible results since reset
// Build option: define MOD3_DIV_COUNT_EN to add the div_count output.
module mod3_serial_ctrl
   import mod3_pkg::*;
#(
   parameter int W = 8
)(
   input  logic         Clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] Data,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [1:0]   REM,
   output logic         divisible
`ifdef MOD3_DIV_COUNT_EN
   ,
   output logic [7:0]   div_count
`endif
);

   localparam int            CW       = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   ctrl_state_t   state_r;
   ctrl_state_t   state_nxt;
   logic [W-1:0]  shreg_r;
   logic [CW-1:0] cnt_r;
   logic          load_s;
   logic          shift_s;
   logic          last_s;
   logic [1:0]    track_rem_s;
   rem_t          rem_final_s;
   logic          ready_r;
   logic          busy_r;
   logic          done_r;
   logic [1:0]    rem_r;
   logic          div_r;

   mod3_bit_fsm u_bit_fsm (
      .Clk    (Clk),
      .reset  (reset),
      .clr    (load_s),
      .en     (shift_s),
      .bit_in (shreg_r[W-1]),
      .rem    (track_rem_s)
   );

   // The tracker only holds the remainder after its edge, so the published
   // result is taken from its next value on the final consume edge.
   assign rem_final_s = rem_next(rem_t'(track_rem_s), shreg_r[W-1]);

   // Next-state and control decode.
   always_comb begin
      state_nxt = IDLE;
      load_s    = 1'b0;
      shift_s   = 1'b0;
      last_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
               load_s    = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            shift_s = 1'b1;
            // <= also catches a counter that somehow reached 0.
            if (cnt_r <= CNT_ONE) begin
               state_nxt = DONE;
               last_s    = 1'b1;
            end else begin
               state_nxt = SHIFT;
            end
         end
         DONE: begin
            if (start) begin
               state_nxt = SHIFT;
               load_s    = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Controller state, datapath and registered status outputs.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         shreg_r <= '0;
         cnt_r   <= '0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rem_r   <= 2'b00;
         div_r   <= 1'b0;
      end else begin
         state_r <= state_nxt;
         if (load_s) begin
            shreg_r <= Data;
            cnt_r   <= CNT_LOAD;
         end else if (shift_s) begin
            shreg_r <= shreg_r << 1;
            cnt_r   <= cnt_r - CNT_ONE;
         end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
         end
         ready_r <= (state_nxt == IDLE) || (state_nxt == DONE);
         busy_r  <= (state_nxt == SHIFT);
         done_r  <= last_s;
         if (last_s) begin
            rem_r <= rem_final_s;
            div_r <= (rem_final_s == R0);
         end else begin
            rem_r <= rem_r;
            div_r <= div_r;
         end
      end
   end

   assign ready     = ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign REM       = rem_r;
   assign divisible = div_r;

`ifdef MOD3_DIV_COUNT_EN
   logic [7:0] div_count_r;

   // Count divisible results; wraps naturally at 8 bits.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         div_count_r <= 8'd0;
      end else if (last_s && (rem_final_s == R0)) begin
         div_count_r <= div_count_r + 8'd1;
      end else begin
         div_count_r <= div_count_r;
      end
   end

   assign div_count = div_count_r;
`endif

endmodule

// File: tb/tb_mod3_serial_ctrl.sv
module tb_mod3_serial_ctrl;

   typedef struct {
      logic [1:0] rem;
      logic       div;
      int         cyc;
   } exp_t;

   logic       Clk;
   logic       reset;
   logic       start8, start1;
   logic [7:0] data8;
   logic [0:0] data1;
   logic       ready8, busy8, done8, div8;
   logic [1:0] rem8;
   logic       ready1, busy1, done1, div1;
   logic [1:0] rem1;
`ifdef MOD3_DIV_COUNT_EN
   logic [7:0] dcnt8, dcnt1;
`endif

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q8[$];
   exp_t q1[$];
   exp_t e8, e1;

   mod3_serial_ctrl #(.W(8)) dut8 (
      .Clk(Clk), .reset(reset), .start(start8), .Data(data8),
      .ready(ready8), .busy(busy8), .done(done8), .REM(rem8), .divisible(div8)
`ifdef MOD3_DIV_COUNT_EN
      , .div_count(dcnt8)
`endif
   );

   mod3_serial_ctrl #(.W(1)) dut1 (
      .Clk(Clk), .reset(reset), .start(start1), .Data(data1),
      .ready(ready1), .busy(busy1), .done(done1), .REM(rem1), .divisible(div1)
`ifdef MOD3_DIV_COUNT_EN
      , .div_count(dcnt1)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc = cyc + 1;

   // Scoreboard for the W=8 instance: every done pulse must match the oldest expectation.
   always @(negedge Clk) begin
      if (done8 === 1'b1) begin
         total++;
         if (q8.size() == 0) begin
            bad++;
            $display("FAIL dut8_spurious_done: done=1 at cycle %0d, required no pulse", cyc);
         end else begin
            e8 = q8.pop_front();
            if (rem8 !== e8.rem) begin
               bad++;
               $display("FAIL dut8_rem: got %0d, required %0d", rem8, e8.rem);
            end
            total++;
            if (div8 !== e8.div) begin
               bad++;
               $display("FAIL dut8_divisible: got %0b, required %0b", div8, e8.div);
            end
            total++;
            if (cyc != e8.cyc) begin
               bad++;
               $display("FAIL dut8_done_cycle: got %0d, required %0d", cyc, e8.cyc);
            end
         end
      end
   end

   // Scoreboard for the W=1 instance.
   always @(negedge Clk) begin
      if (done1 === 1'b1) begin
         total++;
         if (q1.size() == 0) begin
            bad++;
            $display("FAIL dut1_spurious_done: done=1 at cycle %0d, required no pulse", cyc);
         end else begin
            e1 = q1.pop_front();
            if (rem1 !== e1.rem) begin
               bad++;
               $display("FAIL dut1_rem: got %0d, required %0d", rem1, e1.rem);
            end
            total++;
            if (div1 !== e1.div) begin
               bad++;
               $display("FAIL dut1_divisible: got %0b, required %0b", div1, e1.div);
            end
            total++;
            if (cyc != e1.cyc) begin
               bad++;
               $display("FAIL dut1_done_cycle: got %0d, required %0d", cyc, e1.cyc);
            end
         end
      end
   end

   // Called just after a falling edge: present d for one accepted start edge.
   task automatic op8(input logic [7:0] d, input bit expect_done);
      int r;
      total++;
      if (ready8 !== 1'b1) begin
         bad++;
         $display("FAIL op8_ready: got %0b, required 1", ready8);
      end
      r = int'(d) % 3;
      start8 = 1'b1;
      data8  = d;
      if (expect_done) q8.push_back('{rem: 2'(r), div: (r == 0), cyc: cyc + 1 + 8});
      @(negedge Clk);
      start8 = 1'b0;
   endtask

   task automatic op1(input logic [0:0] d);
      int r;
      total++;
      if (ready1 !== 1'b1) begin
         bad++;
         $display("FAIL op1_ready: got %0b, required 1", ready1);
      end
      r = int'(d) % 3;
      start1 = 1'b1;
      data1  = d;
      q1.push_back('{rem: 2'(r), div: (r == 0), cyc: cyc + 1 + 1});
      @(negedge Clk);
      start1 = 1'b0;
   endtask

   task automatic wait8(output int nbusy);
      nbusy = 0;
      for (int i = 0; i < 40 && q8.size() != 0; i++) begin
         if (busy8 === 1'b1) nbusy++;
         @(negedge Clk);
      end
      total++;
      if (q8.size() != 0) begin
         bad++;
         $display("FAIL wait8_timeout: %0d results outstanding, required 0", q8.size());
      end
      @(negedge Clk);
   endtask

   task automatic wait1();
      for (int i = 0; i < 20 && q1.size() != 0; i++) @(negedge Clk);
      total++;
      if (q1.size() != 0) begin
         bad++;
         $display("FAIL wait1_timeout: %0d results outstanding, required 0", q1.size());
      end
      @(negedge Clk);
   endtask

   task automatic check_reset_vals(input string tag);
      total++;
      if ({ready8, busy8, done8, rem8, div8} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0}) begin
         bad++;
         $display("FAIL %s: ready/busy/done/REM/div got %b%b%b/%0d/%b, required 100/0/0",
                  tag, ready8, busy8, done8, rem8, div8);
      end
      total++;
      if ({ready1, busy1, done1, rem1, div1} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0}) begin
         bad++;
         $display("FAIL %s_w1: ready/busy/done/REM/div got %b%b%b/%0d/%b, required 100/0/0",
                  tag, ready1, busy1, done1, rem1, div1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge Clk);
      check_reset_vals("reset_state");
      reset = 1'b0;
      @(negedge Clk);
      check_reset_vals("idle_after_reset");
   endtask

   task automatic test_basic();
      int nb;
      op8(8'h09, 1'b1);
      wait8(nb);
      total++;
      if (nb != 8) begin
         bad++;
         $display("FAIL basic_busy_cycles: got %0d, required 8", nb);
      end
      op8(8'h0B, 1'b1);
      // Previous result must hold while the new word shifts.
      total++;
      if (busy8 !== 1'b1 || rem8 !== 2'd0 || div8 !== 1'b1) begin
         bad++;
         $display("FAIL basic_hold_in_shift: busy/REM/div got %b/%0d/%b, required 1/0/1",
                  busy8, rem8, div8);
      end
      wait8(nb);
      op8(8'h2A, 1'b1);
      wait8(nb);
   endtask

   task automatic test_back_to_back();
      int k;
      int nb;
      k = cyc;
      start8 = 1'b1;
      data8  = 8'hFF;
      q8.push_back('{rem: 2'd0, div: 1'b1, cyc: k + 9});
      @(negedge Clk);
      data8 = 8'h07;
      q8.push_back('{rem: 2'd1, div: 1'b0, cyc: k + 18});
      while (cyc < k + 10) @(negedge Clk);
      start8 = 1'b0;
      wait8(nb);
   endtask

   task automatic test_ignore_start();
      int nb;
      op8(8'h05, 1'b1);
      for (int i = 0; i < 3; i++) begin
         start8 = 1'b1;
         data8  = 8'h0C + 8'(i);
         @(negedge Clk);
         start8 = 1'b0;
         @(negedge Clk);
      end
      data8 = 8'h00;
      wait8(nb);
   endtask

   task automatic test_abort();
      int nb;
      op8(8'h10, 1'b0);
      repeat (2) @(negedge Clk);
      reset = 1'b1;
      #1;
      check_reset_vals("abort_reset_vals");
      @(negedge Clk);
      reset = 1'b0;
      repeat (12) @(negedge Clk);
      op8(8'h03, 1'b1);
      wait8(nb);
   endtask

   task automatic test_w1();
      op1(1'b1);
      wait1();
      op1(1'b0);
      wait1();
      op1(1'b1);
      wait1();
   endtask

`ifdef MOD3_DIV_COUNT_EN
   task automatic test_div_count();
      int nb;
      reset = 1'b1;
      @(negedge Clk);
      reset = 1'b0;
      @(negedge Clk);
      total++;
      if (dcnt8 !== 8'd0) begin
         bad++;
         $display("FAIL divcnt_reset: got %0d, required 0", dcnt8);
      end
      op8(8'd3, 1'b1); wait8(nb);
      op8(8'd4, 1'b1); wait8(nb);
      op8(8'd6, 1'b1); wait8(nb);
      op8(8'd9, 1'b1); wait8(nb);
      total++;
      if (dcnt8 !== 8'd3) begin
         bad++;
         $display("FAIL divcnt_three: got %0d, required 3", dcnt8);
      end
      for (int i = 0; i < 253; i++) begin
         op8(8'(3 * (i % 80)), 1'b1);
         wait8(nb);
      end
      total++;
      if (dcnt8 !== 8'd0) begin
         bad++;
         $display("FAIL divcnt_wrap: got %0d, required 0", dcnt8);
      end
   endtask
`endif

   initial begin
      reset  = 1'b1;
      start8 = 1'b0;
      start1 = 1'b0;
      data8  = 8'h00;
      data1  = 1'b0;
      @(negedge Clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_start();
      test_abort();
      test_w1();
`ifdef MOD3_DIV_COUNT_EN
      test_div_count();
`endif
      repeat (4) @(negedge Clk);
      total++;
      if (q8.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL outstanding_results: got %0d/%0d, required 0/0", q8.size(), q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod3_serial_ctrl.md
Name: mod3_serial_ctrl

Overview:
- Sequencer for a bit-serial remainder-mod-3 datapath.
- Accepts a parallel W-bit word on a start handshake and clears the remainder tracker.
- Shifts the word MSB-first into the tracker, one bit per clock, then reports the remainder and a divisible-by-3 flag with a one-cycle done pulse.
- Sits between a parallel host interface and the bit-serial remainder FSM.

Parameters:
- W, 8, operand width in bits; legal range is W >= 1.
- CW, $clog2(W+1), bit-counter width; derived, not overridden.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces all state to reset values immediately.
- start  input  1  request to process Data; sampled only when ready=1.
- Data  input  W  operand; captured on the accepted start edge.
- ready  output  1  high in IDLE and DONE; start is accepted this cycle.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse; REM and divisible are valid from this cycle on.
- REM  output  2  remainder of Data mod 3; values 0, 1, 2 only.
- divisible  output  1  (REM == 0) for the last completed operation.

Behaviour:
- Reset values: state=IDLE, shift register=0, counter=0, tracker=R0, ready=1, busy=0, done=0, REM=0, divisible=0.
- Tracker update per consumed bit b: r' = (2r + b) mod 3.
  - R0: b=0 -> R0, b=1 -> R1.
  - R1: b=0 -> R2, b=1 -> R0.
  - R2: b=0 -> R1, b=1 -> R2.
- IDLE: on start=1 at edge E0:
  - load shift register with Data, counter=W, tracker=R0;
  - go to SHIFT.
- SHIFT, each edge:
  - consume the shift register MSB into the tracker;
  - shift left by 1 and decrement the counter;
  - when the counter was 1 before the edge, go to DONE.
- Latency: start accepted at E0 gives done=1 in the cycle after edge E0+W; this is W cycles of busy.
- DONE (one cycle):
  - done=1; REM and divisible reflect the final tracker value.
  - Next edge goes to IDLE, or back to SHIFT if start=1, which loads the new word.
- REM and divisible hold the last result until the next done; they do not change during SHIFT.
- Boundary rules:
  - start during SHIFT is ignored: no reload, no queueing.
  - start held high continuously gives back-to-back operations with period W+1 cycles.
  - reset asserted mid-SHIFT aborts the operation; no done pulse is issued; outputs return to reset values.
  - W=1: E0 loads, E1 consumes the single bit, done is high in the next cycle.
  - An unreachable state encoding recovers to IDLE on the next edge.
  - An unreachable tracker encoding recovers to R0 on the next edge.

Optional Feature:
- Macro: MOD3_DIV_COUNT_EN.
- Defined:
  - adds output div_count [7:0], reset to 0;
  - increments in the cycle done=1 when the result is divisible;
  - wraps 255 -> 0;
  - cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mod3_pkg:
  - controller state encoding IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - remainder encoding R0=2'b00, R1=2'b01, R2=2'b10;
  - the remainder transition function.
- One sub-module: mod3_bit_fsm, the bit-serial tracker.
  - Ports: Clk, reset, clr, en, bit_in, rem[1:0].
  - clr has priority over en.
  - The controller drives clr on accepted start and en during SHIFT.

Test Plan:
- W=8, Data=8'h09 -> after 8 busy cycles: done=1, REM=0, divisible=1; Data=8'h0B -> REM=2, divisible=0.
- W=8, Data=8'hFF then 8'h07 back-to-back with start held -> REM=0 then REM=1; done pulses exactly 9 cycles apart.
- start pulses during SHIFT of Data=8'h05 -> ignored; result REM=2 at the original expected cycle.
- reset asserted 3 cycles into SHIFT -> outputs are at reset values immediately; no done pulse; the next start with 8'h03 gives REM=0.
- W=1 build, Data=1 -> done one cycle after the consume edge, REM=1; Data=0 -> REM=0, divisible=1.
- MOD3_DIV_COUNT_EN defined, operands 3, 4, 6, 9 -> div_count=3; 256 divisible results -> div_count wraps to 0.
